// File: rtl/decode_align_queue.sv
// decode_align_queue: instruction alignment queue between fetch and decode.
// Fetch words are stored as halfword slots and one aligned instruction is
// presented per cycle together with pc, npc and any attached fetch fault.
// Optional feature macro RVC_EN: when defined, 16-bit compressed instructions
// are recognised and redirects to an odd halfword drop the first low half.
// When undefined, every instruction is 32 bits and a redirect to an odd
// halfword raises an instruction-address-misaligned fault until the next clear.
module decode_align_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fetch_valid,
  output logic                      fetch_ready,
  input  logic [31:0]               fetch_rdata,
  input  logic                      fetch_error,
  input  logic                      clear,
  input  logic [XLEN-1:0]           clear_pc,
  input  logic                      stall,
  output logic                      dec_valid,
  output logic [31:0]               dec_instr,
  output logic [XLEN-1:0]           dec_pc,
  output logic [XLEN-1:0]           dec_npc,
  output logic                      dec_exception,
  output logic [3:0]                dec_ecause,
  output logic [XLEN-1:0]           dec_etval,
  output logic [$clog2(2*DEPTH):0]  count
);
  localparam int unsigned SLOTS = 2 * DEPTH;
  localparam int unsigned PW    = $clog2(SLOTS);
  localparam int unsigned CW    = PW + 1;

  logic [15:0]     slot_data [SLOTS];
  logic            slot_err  [SLOTS];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] pc_q;
  // Set by a clear to an odd halfword. With RVC_EN it means "drop the low
  // half of the next fetch word"; without it the head is a misaligned fault.
  logic            odd_redirect;

  logic [15:0]     h0, h1;
  logic            h0_err, h1_err;
  logic            short_instr, head_hold, push, pop;
  logic [CW-1:0]   push_n, pop_n;

  // Head decode, handshake and presentation of the aligned instruction
  always_comb begin
    h0     = slot_data[rd_ptr];
    h0_err = slot_err[rd_ptr];
    h1     = slot_data[rd_ptr + PW'(1)];
    h1_err = slot_err[rd_ptr + PW'(1)];
`ifdef RVC_EN
    // A faulting first halfword has no trustworthy length bits: treat as 2 bytes.
    short_instr = h0_err | (h0[1:0] != 2'b11);
    head_hold   = 1'b0;
`else
    short_instr = 1'b0;
    head_hold   = odd_redirect;
`endif
    fetch_ready = (CW'(SLOTS) - cnt_q) >= CW'(2);
    dec_valid   = head_hold |
                  ((cnt_q != '0) & (short_instr | h0_err | (cnt_q >= CW'(2))));
    push        = fetch_valid & fetch_ready;
    pop         = dec_valid & ~stall & ~head_hold;
`ifdef RVC_EN
    push_n      = push ? (odd_redirect ? CW'(1) : CW'(2)) : '0;
`else
    push_n      = push ? CW'(2) : '0;
`endif
    pop_n       = pop ? (short_instr ? CW'(1) : CW'(2)) : '0;

    dec_pc        = pc_q;
    dec_npc       = pc_q + (short_instr ? XLEN'(2) : XLEN'(4));
    dec_exception = 1'b0;
    dec_ecause    = 4'd0;
    dec_etval     = '0;
    dec_instr     = '0;
    if (dec_valid) begin
      if (head_hold) begin
        dec_exception = 1'b1;
        dec_ecause    = 4'd0;
        dec_etval     = pc_q;
      end else if (h0_err) begin
        dec_exception = 1'b1;
        dec_ecause    = 4'd1;
        dec_etval     = pc_q;
      end else if (!short_instr && h1_err) begin
        dec_exception = 1'b1;
        dec_ecause    = 4'd1;
        dec_etval     = pc_q + XLEN'(2);
      end else if (short_instr) begin
        dec_instr = {16'h0000, h0};
      end else begin
        dec_instr = {h1, h0};
      end
    end
    count = cnt_q;
  end

  // Pointers, occupancy, pc and redirect state; clear overrides push and pop
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      cnt_q        <= '0;
      pc_q         <= PC_RESET;
      odd_redirect <= 1'b0;
    end else if (clear) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      cnt_q        <= '0;
      pc_q         <= clear_pc;
      odd_redirect <= clear_pc[1];
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(push_n);
`ifdef RVC_EN
        odd_redirect <= 1'b0;
`endif
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(pop_n);
        pc_q   <= dec_npc;
      end
      cnt_q <= cnt_q + push_n - pop_n;
    end
  end

  // Halfword storage; a dropped low half puts the high half in the write slot
  always_ff @(posedge clk) begin
    if (!rst && !clear && push) begin
      if (push_n == CW'(1)) begin
        slot_data[wr_ptr] <= fetch_rdata[31:16];
        slot_err[wr_ptr]  <= fetch_error;
      end else begin
        slot_data[wr_ptr]          <= fetch_rdata[15:0];
        slot_err[wr_ptr]           <= fetch_error;
        slot_data[wr_ptr + PW'(1)] <= fetch_rdata[31:16];
        slot_err[wr_ptr + PW'(1)]  <= fetch_error;
      end
    end
  end

endmodule

// File: tb/tb_decode_align_queue.sv
// tb_decode_align_queue: directed and random stimulus against a halfword-queue
// reference model; honours RVC_EN the same way the design does.
module tb_decode_align_queue;
  localparam int SLOTS = 8;
  localparam logic [31:0] PC_RESET = 32'h0;
`ifdef RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, fetch_valid, fetch_ready, fetch_error, clear, stall;
  logic        dec_valid, dec_exception;
  logic [31:0] fetch_rdata, clear_pc, dec_instr, dec_pc, dec_npc, dec_etval;
  logic [3:0]  dec_ecause, count;

  always #5 clk = ~clk;

  decode_align_queue #(.XLEN(32), .DEPTH(4), .PC_RESET(PC_RESET)) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_rdata(fetch_rdata), .fetch_error(fetch_error), .clear(clear),
    .clear_pc(clear_pc), .stall(stall), .dec_valid(dec_valid), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .dec_npc(dec_npc), .dec_exception(dec_exception),
    .dec_ecause(dec_ecause), .dec_etval(dec_etval), .count(count)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        e;
  } hw_t;

  hw_t         q[$];
  logic [31:0] m_pc;
  bit          m_odd;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected head, straight from the queue contents in instruction terms.
  function automatic void expect_now(output bit v, output bit exc, output logic [3:0] ec,
                                     output logic [31:0] tv, output logic [31:0] ins,
                                     output logic [31:0] npc, output int len);
    v = 0; exc = 0; ec = 0; tv = 0; ins = 0; len = 4;
    npc = m_pc + 32'd4;
    if (!RVC && m_odd) begin
      v = 1; exc = 1; ec = 0; tv = m_pc;
      return;
    end
    if (q.size() == 0) return;
    if (RVC && (q[0].e || q[0].d[1:0] != 2'b11)) len = 2;
    npc = m_pc + 32'(len);
    v = q[0].e || (q.size() * 2 >= len);
    if (!v) return;
    if (q[0].e) begin
      exc = 1; ec = 1; tv = m_pc;
    end else if (len == 4 && q[1].e) begin
      exc = 1; ec = 1; tv = m_pc + 32'd2;
    end else if (len == 2) begin
      ins = {16'h0000, q[0].d};
    end else begin
      ins = {q[1].d, q[0].d};
    end
  endfunction

  // One clock: check outputs against the model, drive inputs, advance the model.
  task automatic step(bit r, bit fv, logic [31:0] wd, bit fe, bit cl, logic [31:0] cpc, bit st);
    bit v, exc, rdy;
    logic [3:0] ec;
    logic [31:0] tv, ins, npc;
    int len;
    @(negedge clk);
    expect_now(v, exc, ec, tv, ins, npc, len);
    rdy = (SLOTS - q.size()) >= 2;
    chk("count", count, q.size());
    chk("fetch_ready", fetch_ready, rdy);
    chk("dec_valid", dec_valid, v);
    chk("dec_pc", dec_pc, m_pc);
    if (v) begin
      chk("dec_exception", dec_exception, exc);
      chk("dec_npc", dec_npc, npc);
      if (exc) begin
        chk("dec_ecause", dec_ecause, ec);
        chk("dec_etval", dec_etval, tv);
      end else begin
        chk("dec_instr", dec_instr, ins);
      end
    end
    rst = r; fetch_valid = fv; fetch_rdata = wd; fetch_error = fe;
    clear = cl; clear_pc = cpc; stall = st;
    if (r) begin
      q.delete(); m_pc = PC_RESET; m_odd = 0;
    end else if (cl) begin
      q.delete(); m_pc = cpc; m_odd = cpc[1];
    end else begin
      if (v && !st && !(!RVC && m_odd)) begin
        for (int k = 0; k < len / 2; k++)
          if (q.size() > 0) void'(q.pop_front());
        m_pc = m_pc + 32'(len);
      end
      if (fv && rdy) begin
        if (RVC && m_odd) begin
          q.push_back('{d: wd[31:16], e: fe});
          m_odd = 0;
        end else begin
          q.push_back('{d: wd[15:0], e: fe});
          q.push_back('{d: wd[31:16], e: fe});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [31:0] wd, bit fe, bit st);
    step(0, 1, wd, fe, 0, 32'h0, st);
  endtask

  task automatic idle(bit st);
    step(0, 0, 32'h0, 0, 0, 32'h0, st);
  endtask

  task automatic do_clear(logic [31:0] cpc);
    step(0, 0, 32'h0, 0, 1, cpc, 0);
  endtask

  initial begin
    bit found;
    rst = 1; fetch_valid = 0; fetch_rdata = 0; fetch_error = 0;
    clear = 0; clear_pc = 0; stall = 0;
    repeat (2) @(posedge clk);
    #1;
    q.delete(); m_pc = PC_RESET; m_odd = 0;
    chk("reset_count", count, 0);
    chk("reset_ready", fetch_ready, 1);
    chk("reset_valid", dec_valid, 0);
    chk("reset_exception", dec_exception, 0);
    chk("reset_instr", dec_instr, 0);
    chk("reset_ecause", dec_ecause, 0);
    chk("reset_etval", dec_etval, 0);
    chk("reset_pc", dec_pc, PC_RESET);

    // two plain 32-bit instructions, one per cycle
    push(32'h00130093, 0, 0);
    chk("seq_instr0", dec_instr, 32'h00130093);
    chk("seq_npc0", dec_npc, 32'h4);
    push(32'h00230113, 0, 0);
    chk("seq_pc1", dec_pc, 32'h4);
    chk("seq_npc1", dec_npc, 32'h8);
    idle(0); idle(0);

    // two compressed halves of one word
    do_clear(32'h100);
    push(32'h45014481, 0, 1);
`ifdef RVC_EN
    chk("rvc_instr0", dec_instr, 32'h00004481);
    chk("rvc_npc0", dec_npc, 32'h102);
`else
    chk("rvc_instr0", dec_instr, 32'h45014481);
    chk("rvc_npc0", dec_npc, 32'h104);
`endif
    idle(0); idle(0); idle(0);

    // 32-bit instruction straddling two fetch words
    do_clear(32'h0);
    push(32'h00934501, 0, 0);
    push(32'h00000000, 0, 0);
    idle(0); idle(0); idle(0);

    // redirect to odd halfword
    do_clear(32'h202);
    push(32'h00A30001, 0, 1);
`ifdef RVC_EN
    chk("odd_count", count, 1);
    chk("odd_pc", dec_pc, 32'h202);
`endif
    push(32'h00000001, 0, 0);
    idle(0); idle(0);

`ifndef RVC_EN
    do_clear(32'h6);
    push(32'h00130093, 0, 0);
    chk("mis_valid", dec_valid, 1);
    chk("mis_exception", dec_exception, 1);
    chk("mis_ecause", dec_ecause, 0);
    chk("mis_etval", dec_etval, 32'h6);
    chk("mis_instr", dec_instr, 0);
    idle(0); idle(0);
`endif

    // fill under stall, then clear on the same cycle as a push
    do_clear(32'h0);
    for (int i = 0; i < 4; i++) push(32'h00130093 + 32'(i << 20), 0, 1);
    chk("full_count", count, 8);
    chk("full_ready", fetch_ready, 0);
    push(32'h00230113, 0, 1);
    do_clear(32'h0);
    push(32'h00130093, 0, 1);
    step(0, 1, 32'h00230113, 0, 1, 32'h0, 1);
    chk("clear_count", count, 0);
    chk("clear_valid", dec_valid, 0);

    // access fault on the second word of a straddling instruction
    do_clear(32'h1C);
    push(32'h00934501, 0, 1);
    push(32'h12345678, 1, 1);
    found = 0;
    for (int i = 0; i < 8; i++) begin
      if (dec_valid && dec_exception) begin
        found = 1;
        break;
      end
      idle(0);
    end
    chk("fault_seen", found, 1);
    chk("fault_ecause", dec_ecause, 1);
    chk("fault_etval", dec_etval, 32'h20);
    idle(0); idle(0);

    // pc wrap at the top of the address space
    do_clear(32'hFFFF_FFFC);
    push(32'h00130093, 0, 0);
    chk("wrap_npc", dec_npc, 32'h0);
    push(32'h00230113, 0, 0);
    idle(0); idle(0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit r, fv, fe, cl, st;
      logic [31:0] cpc;
      r   = ($urandom_range(0, 199) == 0);
      fv  = ($urandom_range(0, 9) < 7);
      fe  = ($urandom_range(0, 15) == 0);
      cl  = ($urandom_range(0, 39) == 0);
      st  = ($urandom_range(0, 9) < 3);
      cpc = $urandom & 32'hFFFF_FFFE;
      step(r, fv, $urandom, fe, cl, cpc, st);
    end
    idle(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
